// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD programmable counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // What the count register does on the next edge (reset is handled separately).
  typedef enum logic [1:0] {
    ActHold,
    ActLoad,
    ActStep,
    ActEndpoint
  } bcd_action_e;

  // Any non-decimal nibble (A-F) is treated as 9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the step chain: increments or decrements when enabled and
// reports carry (up) or borrow (down) into the next more significant digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       en,
  input  logic       up,
  output bcd_digit_t digit_next,
  output logic       carry
);

  // Single-digit step with 9->0 / 0->9 rollover.
  always_comb begin
    digit_next = digit;
    carry      = 1'b0;
    if (en) begin
      if (up) begin
        if (digit >= BCD_MAX) begin
          digit_next = BCD_MIN;
          carry      = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_MIN) begin
          digit_next = BCD_MAX;
          carry      = 1'b1;
        end else if (digit > BCD_MAX) begin
          // Out-of-range digit cannot arise after reset; land on a valid value anyway.
          digit_next = BCD_MAX - 4'd1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_prog_counter.sv
// Multi-digit BCD counter with programmable terminal value, up/down counting,
// parallel load, run/stop control and wrap-or-hold endpoint behaviour.
module bcd_prog_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                run,
  input  logic                stop,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] term_val,
  output logic [4*DIGITS-1:0] count_out,
  output logic                tc,
  output logic                done
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]  count_q, count_d;
  logic          done_q, done_d;
  logic [W-1:0]  term_c;
  logic [W-1:0]  load_c;
  logic [W-1:0]  step_val;
  logic [W-1:0]  end_val;
  logic [DIGITS:0] carry;
  logic          at_top;
  logic          at_zero;
  logic          end_hit;
  bcd_action_e   action;

  // Digit 0 always steps; each higher digit steps only on carry/borrow from below.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign term_c[4*i +: 4] = bcd_clamp(term_val[4*i +: 4]);
    assign load_c[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);

    bcd_digit u_digit (
      .digit      (count_q[4*i +: 4]),
      .en         (carry[i]),
      .up         (up),
      .digit_next (step_val[4*i +: 4]),
      .carry      (carry[i+1])
    );
  end

  // With valid BCD in every digit, plain unsigned compare matches decimal order.
  assign at_top  = (count_q >= term_c);
  assign at_zero = (count_q == '0);
  assign tc      = up ? at_top : at_zero;

  // A carry out of the top digit only happens at all-9s (up) or all-0s (down), both
  // already covered by tc; folding it in guarantees the chain can never overflow.
  assign end_hit = tc | carry[DIGITS];

  // Value taken when an endpoint is hit while counting.
  always_comb begin
    end_val = '0;
    if (WRAP) begin
      end_val = up ? '0 : term_c;
    end else begin
      end_val = up ? term_c : '0;
    end
  end

  // Priority decode below reset: load, then counting, else hold.
  always_comb begin
    action = ActHold;
    if (load) begin
      action = ActLoad;
    end else if (run && !stop) begin
      action = end_hit ? ActEndpoint : ActStep;
    end
  end

  // Next-state for count and the sticky done flag.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    unique case (action)
      ActLoad: begin
        count_d = load_c;
        done_d  = 1'b0;
      end
      ActStep: begin
        count_d = step_val;
      end
      ActEndpoint: begin
        count_d = end_val;
        if (!WRAP) done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_out = count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bcd_prog_counter.sv
// Scoreboard bench for bcd_prog_counter: a wrapping and a holding instance share
// stimulus; a decimal integer model predicts both and results are queued per edge.
module tb_bcd_prog_counter;

  logic       CLK;
  logic       RST;
  logic       run;
  logic       stop;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] term_val;
  logic [7:0] cnt_w, cnt_h;
  logic       tc_w, tc_h, done_w, done_h;

  int n_checks = 0;
  int n_errors = 0;
  int n_step   = 0;

  typedef struct {
    logic [7:0] cnt_w;
    logic [7:0] cnt_h;
    logic       tc_w;
    logic       tc_h;
    logic       done_w;
    logic       done_h;
  } exp_t;

  exp_t sb[$];

  // Model state: plain decimal integers plus sticky done flags.
  int m_w = 0;
  int m_h = 0;
  bit d_w = 1'b0;
  bit d_h = 1'b0;

  bcd_prog_counter #(.DIGITS(2), .WRAP(1'b1)) u_dut_wrap (
    .CLK       (CLK),
    .RST       (RST),
    .run       (run),
    .stop      (stop),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .term_val  (term_val),
    .count_out (cnt_w),
    .tc        (tc_w),
    .done      (done_w)
  );

  bcd_prog_counter #(.DIGITS(2), .WRAP(1'b0)) u_dut_hold (
    .CLK       (CLK),
    .RST       (RST),
    .run       (run),
    .stop      (stop),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .term_val  (term_val),
    .count_out (cnt_h),
    .tc        (tc_h),
    .done      (done_h)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s step=%0d: got %h expected %h", tag, n_step, got, exp);
    end
  endtask

  function automatic int to_int(input logic [7:0] v);
    int hi, lo;
    hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] hi, lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  task automatic model_step(input bit w, input int m, input bit d, input logic r,
                            input logic ld, input logic [7:0] lv, input logic rn,
                            input logic st, input logic u, input logic [7:0] tv,
                            output int m_n, output bit d_n);
    int t;
    t   = to_int(tv);
    m_n = m;
    d_n = d;
    if (r) begin
      m_n = 0;
      d_n = 1'b0;
    end else if (ld) begin
      m_n = to_int(lv);
      d_n = 1'b0;
    end else if (rn && !st) begin
      if (u) begin
        if (m >= t) begin
          if (w) m_n = 0;
          else begin
            m_n = t;
            d_n = 1'b1;
          end
        end else begin
          m_n = m + 1;
        end
      end else begin
        if (m == 0) begin
          if (w) m_n = t;
          else d_n = 1'b1;
        end else begin
          m_n = m - 1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, push the prediction, then pop and compare after the edge.
  task automatic tick(input logic r, input logic ld, input logic [7:0] lv, input logic rn,
                      input logic st, input logic u, input logic [7:0] tv);
    exp_t e, g;
    int   t;
    @(negedge CLK);
    RST      = r;
    load     = ld;
    load_val = lv;
    run      = rn;
    stop     = st;
    up       = u;
    term_val = tv;
    model_step(1'b1, m_w, d_w, r, ld, lv, rn, st, u, tv, m_w, d_w);
    model_step(1'b0, m_h, d_h, r, ld, lv, rn, st, u, tv, m_h, d_h);
    t        = to_int(tv);
    e.cnt_w  = to_bcd(m_w);
    e.cnt_h  = to_bcd(m_h);
    e.tc_w   = u ? (m_w >= t) : (m_w == 0);
    e.tc_h   = u ? (m_h >= t) : (m_h == 0);
    e.done_w = d_w;
    e.done_h = d_h;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    n_step++;
    g = sb.pop_front();
    check("count_wrap", cnt_w, g.cnt_w);
    check("count_hold", cnt_h, g.cnt_h);
    check("tc_wrap", {7'd0, tc_w}, {7'd0, g.tc_w});
    check("tc_hold", {7'd0, tc_h}, {7'd0, g.tc_h});
    check("done_wrap", {7'd0, done_w}, {7'd0, g.done_w});
    check("done_hold", {7'd0, done_h}, {7'd0, g.done_h});
  endtask

  // Count-only cycle helper.
  task automatic run_n(input int n, input logic u, input logic [7:0] tv);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, u, tv);
  endtask

  task automatic do_load(input logic [7:0] lv, input logic u, input logic [7:0] tv);
    tick(1'b0, 1'b1, lv, 1'b0, 1'b0, u, tv);
  endtask

  initial begin
    RST = 1'b0; load = 1'b0; load_val = '0; run = 1'b0;
    stop = 1'b0; up = 1'b1; term_val = 8'h25;

    // Reset beats a simultaneous load.
    tick(1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 8'h25);

    // Reset mid-count at 37.
    do_load(8'h35, 1'b1, 8'h99);
    run_n(2, 1'b1, 8'h99);
    tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99);

    // Up count 00..25 then wrap (or hold with done).
    run_n(28, 1'b1, 8'h25);

    // Down from 03 to 00, then hold with done set until the next load.
    do_load(8'h03, 1'b0, 8'h25);
    run_n(6, 1'b0, 8'h25);

    // Pause and disable at 14, then resume.
    do_load(8'h14, 1'b1, 8'h99);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99);
    run_n(1, 1'b1, 8'h99);

    // Clamped load value, then terminal lowered below the count.
    do_load(8'hAB, 1'b1, 8'h99);
    do_load(8'h50, 1'b1, 8'h99);
    run_n(2, 1'b1, 8'h30);

    // Full-scale up, zero down, then an unclamped terminal value.
    do_load(8'h99, 1'b1, 8'h99);
    run_n(1, 1'b1, 8'h99);
    do_load(8'h00, 1'b0, 8'h99);
    run_n(2, 1'b0, 8'h99);
    do_load(8'h00, 1'b0, 8'hFA);
    run_n(1, 1'b0, 8'hFA);

    // Direction toggled every counting edge.
    do_load(8'h50, 1'b1, 8'h99);
    for (int i = 0; i < 4; i++) run_n(1, (i % 2 == 0) ? 1'b1 : 1'b0, 8'h99);

    // Mixed random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] lv, tv;
      lv = 8'($urandom);
      tv = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h25;
      tick(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0), lv,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), tv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
